udp_tx_msg_gen: RTL
===================

Name: udp_tx_msg_gen

Overview:
- Application-side producer for the UDP TX buffer port of ros2_ether.
- Accepts a byte stream plus destination/port fields and packs the datagram into an internal word buffer in UDP TX buffer layout.
- Hands the buffer to ros2_ether with the grant/release handshake, then serves its txbuf_addr reads.
- Replaces hard-wired txbuf_rdata tables in top levels.

Parameters:
- AWIDTH, 6, TX buffer word-address width; must equal `UDP_TXBUF_AWIDTH.
- MAX_BYTES, (2**AWIDTH-3)*4 = 244, payload byte capacity.
- FLUSH_TIMEOUT, 1250000, idle cycles before auto-flush (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_tdata  in  8  payload byte
- s_tvalid  in  1  byte valid
- s_tready  out  1  byte accepted when tvalid&tready
- s_tlast  in  1  last byte of datagram
- dst_ip  in  32  destination IP, byte-reversed as in ip_addr (192.168.1.10 = 32'h0a01a8c0)
- dst_port  in  16  UDP destination port
- src_port  in  16  UDP source port
- txbuf_cpu_grant  in  1  high while ros2_ether leaves the buffer to this block
- txbuf_cpu_rel  out  1  one-cycle pulse: datagram ready, buffer handed to ros2_ether
- txbuf_addr  in  AWIDTH  word read address from ros2_ether
- txbuf_rdata  out  32  read data, registered
- sent_cnt  out  16  datagrams released, wraps at 65535->0
- drop  out  1  sticky: bytes discarded by overflow since reset

Behaviour:
- Buffer layout:
  - word0 = dst_ip.
  - word1 = {dst_port, src_port}.
  - word2 = {16'h0, byte_len}.
  - word3+ = payload, little-endian: byte n at word 3+n/4, bits [8*(n%4)+7 : 8*(n%4)].
- Payload is held in internal RAM/regs of 2**AWIDTH-3 words. Unused bytes of the last word are 0.
- dst_ip/dst_port/src_port are latched on the accepted beat carrying s_tlast. Latched header values feed word0/word1.
- txbuf_rdata: registered, 1-cycle latency from txbuf_addr in every state. Addresses beyond the payload region read 0.
- FSM:
  - FILL: s_tready=1. Each accepted byte is written at index byte_len, then byte_len++. An accepted beat with s_tlast goes to WAIT_GRANT.
  - WAIT_GRANT: s_tready=0. When txbuf_cpu_grant=1, go to REL.
  - REL: txbuf_cpu_rel=1 for exactly one cycle. sent_cnt++. Go to BUSY_LO.
  - BUSY_LO: wait for txbuf_cpu_grant=0 (ros2_ether reading). Go to BUSY_HI.
  - BUSY_HI: wait for txbuf_cpu_grant=1 (read done). Clear byte_len and payload-valid. Go to FILL.
  - Buffer contents stay stable from WAIT_GRANT until FILL is re-entered.
- Overflow: once byte_len=MAX_BYTES, further bytes are accepted (tready stays 1) but discarded, and drop is set. byte_len saturates at MAX_BYTES. s_tlast still closes the datagram.
- Simultaneous s_tlast and grant already high: WAIT_GRANT lasts one cycle, so rel asserts 2 cycles after the tlast beat.
- Grant glitch: grant dropping in WAIT_GRANT is ignored (keep waiting). Grant never dropping after REL leaves the FSM in BUSY_LO indefinitely (no timeout).
- Reset (any time, asynchronous):
  - state=FILL, byte_len=0, header regs=0, payload=0.
  - txbuf_cpu_rel=0, txbuf_rdata=0, sent_cnt=0, drop=0.
  - s_tready is 1 after reset.
  - A datagram in flight is lost. No rel is emitted for it.

Optional Feature:
- Macro: UDP_TX_MSG_GEN_FLUSH_EN.
- Defined: a counter clears on every accepted beat and increments in FILL while byte_len>0 and no beat is accepted.
  - When it reaches FLUSH_TIMEOUT, the partial datagram closes as if s_tlast arrived.
  - Header is latched from current dst_ip/dst_port/src_port at that cycle. Go to WAIT_GRANT.
  - The counter is held at 0 outside FILL and when byte_len=0.
- Undefined: only s_tlast closes a datagram; no counter logic is synthesised.

Test Plan:
- Basic send, grant=1: send "foobar\n" (7 bytes, tlast on '\n'), dst_ip=32'h0a01a8c0, dst_port=16'h0457, src_port=16'h04d2.
  - rel pulses once, 2 cycles after the tlast beat.
  - Reads of addr 0..5 return 0a01a8c0, 045704d2, 00000007, 626f6f66, 000a7261, 00000000, each 1 cycle after the address.
  - sent_cnt=1.
- Handshake: hold grant=0, send 1 byte with tlast.
  - No rel and tready=0 until grant=1; then exactly one rel.
  - Drop grant for 10 cycles then raise it: tready returns to 1 one cycle after grant rises.
- Overflow, AWIDTH=6: send 250 bytes.
  - word2=244 and drop=1.
  - Last buffered byte is byte 243, in word 63 bits [31:24].
- Reset mid-fill: after 5 bytes assert rst_n=0 for 1 cycle, then send 3 bytes with tlast.
  - word2=3, sent_cnt=1, and no rel was seen before the reset.
- Flush (macro defined, FLUSH_TIMEOUT=100): send 2 bytes without tlast, then idle.
  - rel occurs about 102 cycles after the last byte, with word2=2.
  - With the macro undefined, no rel occurs within 10000 cycles.
- Back-to-back: send 3 datagrams, grant toggling low for 4 cycles after each rel.
  - 3 rel pulses, sent_cnt=3, each word2 matches its datagram's length.

Source files
------------

// File: rtl/udp_tx_msg_gen.sv
// Packs an application byte stream into the ros2_ether UDP TX buffer image and serves its reads.
// Define UDP_TX_MSG_GEN_FLUSH_EN to close a partial datagram after FLUSH_TIMEOUT idle cycles.
module udp_tx_msg_gen #(
  parameter int AWIDTH        = 6,
  parameter int MAX_BYTES     = (2**AWIDTH - 3) * 4,
  parameter int FLUSH_TIMEOUT = 1250000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [31:0]       dst_ip,
  input  logic [15:0]       dst_port,
  input  logic [15:0]       src_port,
  input  logic              txbuf_cpu_grant,
  output logic              txbuf_cpu_rel,
  input  logic [AWIDTH-1:0] txbuf_addr,
  output logic [31:0]       txbuf_rdata,
  output logic [15:0]       sent_cnt,
  output logic              drop
);

  localparam int PWORDS = 2**AWIDTH - 3;

  typedef enum logic [2:0] {
    ST_FILL       = 3'd0,
    ST_WAIT_GRANT = 3'd1,
    ST_REL        = 3'd2,
    ST_BUSY_LO    = 3'd3,
    ST_BUSY_HI    = 3'd4
  } state_t;

  if (MAX_BYTES > PWORDS * 4 || MAX_BYTES > 65535 || FLUSH_TIMEOUT < 2) begin : g_cfg_err
    $error("udp_tx_msg_gen: MAX_BYTES exceeds buffer capacity or FLUSH_TIMEOUT too small");
  end

  state_t              r_state;
  logic [15:0]         r_byte_len;
  logic [31:0]         r_hdr_ip;
  logic [15:0]         r_hdr_dport;
  logic [15:0]         r_hdr_sport;
  logic                r_tready;
  logic                r_rel;
  logic [31:0]         r_rdata;
  logic [15:0]         r_sent_cnt;
  logic                r_drop;
  logic [31:0]         r_payload [PWORDS];

  logic                w_beat;
  logic                w_room;
  logic                w_close;
  logic                w_clear;
  logic [AWIDTH-1:0]   w_wr_word;
  logic [1:0]          w_wr_lane;
  logic [AWIDTH-1:0]   w_rd_idx;
  logic [31:0]         w_rd_data;

  assign w_beat    = s_tvalid & r_tready;
  assign w_room    = (r_byte_len < 16'(MAX_BYTES));
  assign w_wr_word = r_byte_len[AWIDTH+1:2];
  assign w_wr_lane = r_byte_len[1:0];
  assign w_clear   = (r_state == ST_BUSY_HI) & txbuf_cpu_grant;
  assign w_rd_idx  = txbuf_addr - AWIDTH'(3);

`ifdef UDP_TX_MSG_GEN_FLUSH_EN
  localparam int FW = $clog2(FLUSH_TIMEOUT + 1);

  logic [FW-1:0] r_flush_cnt;
  logic          w_flush;

  assign w_flush = (r_state == ST_FILL) && (r_byte_len != 16'd0) && !w_beat &&
                   (r_flush_cnt == FW'(FLUSH_TIMEOUT - 1));
  assign w_close = (w_beat & s_tlast) | w_flush;

  // Idle counter: only runs while a partial datagram sits in FILL with no traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
    end else if (r_state != ST_FILL || r_byte_len == 16'd0 || w_beat || w_flush) begin
      r_flush_cnt <= '0;
    end else begin
      r_flush_cnt <= r_flush_cnt + FW'(1);
    end
  end
`else
  assign w_close = w_beat & s_tlast;
`endif

  // Datagram lifecycle: fill, hand over with the grant/release handshake, then wait for read-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_byte_len  <= 16'd0;
      r_hdr_ip    <= 32'h0;
      r_hdr_dport <= 16'h0;
      r_hdr_sport <= 16'h0;
      r_tready    <= 1'b1;
      r_rel       <= 1'b0;
      r_sent_cnt  <= 16'd0;
      r_drop      <= 1'b0;
    end else begin
      r_rel <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_beat) begin
            if (w_room) begin
              r_byte_len <= r_byte_len + 16'd1;
            end else begin
              r_drop <= 1'b1;
            end
          end
          if (w_close) begin
            r_hdr_ip    <= dst_ip;
            r_hdr_dport <= dst_port;
            r_hdr_sport <= src_port;
            r_tready    <= 1'b0;
            r_state     <= ST_WAIT_GRANT;
          end
        end
        ST_WAIT_GRANT: begin
          if (txbuf_cpu_grant) begin
            r_state <= ST_REL;
          end
        end
        ST_REL: begin
          r_rel      <= 1'b1;
          r_sent_cnt <= r_sent_cnt + 16'd1;
          r_state    <= ST_BUSY_LO;
        end
        ST_BUSY_LO: begin
          if (!txbuf_cpu_grant) begin
            r_state <= ST_BUSY_HI;
          end
        end
        ST_BUSY_HI: begin
          if (txbuf_cpu_grant) begin
            r_byte_len <= 16'd0;
            r_tready   <= 1'b1;
            r_state    <= ST_FILL;
          end
        end
        default: begin
          r_tready <= 1'b1;
          r_state  <= ST_FILL;
        end
      endcase
    end
  end

  // Payload store; wiped when the buffer returns so stale bytes never pad a shorter datagram.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PWORDS; i++) begin
        r_payload[i] <= 32'h0;
      end
    end else if (w_clear) begin
      for (int i = 0; i < PWORDS; i++) begin
        r_payload[i] <= 32'h0;
      end
    end else if (w_beat && w_room) begin
      r_payload[w_wr_word][{w_wr_lane, 3'b000} +: 8] <= s_tdata;
    end
  end

  // Buffer image decode for the ros2_ether read port.
  always_comb begin
    w_rd_data = 32'h0;
    if (txbuf_addr == AWIDTH'(0)) begin
      w_rd_data = r_hdr_ip;
    end else if (txbuf_addr == AWIDTH'(1)) begin
      w_rd_data = {r_hdr_dport, r_hdr_sport};
    end else if (txbuf_addr == AWIDTH'(2)) begin
      w_rd_data = {16'h0, r_byte_len};
    end else if (w_rd_idx < AWIDTH'(PWORDS)) begin
      w_rd_data = r_payload[w_rd_idx];
    end else begin
      w_rd_data = 32'h0;
    end
  end

  // One-cycle registered read latency in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0;
    end else begin
      r_rdata <= w_rd_data;
    end
  end

  assign s_tready      = r_tready;
  assign txbuf_cpu_rel = r_rel;
  assign txbuf_rdata   = r_rdata;
  assign sent_cnt      = r_sent_cnt;
  assign drop          = r_drop;

endmodule
